// File: rtl/sram_pkg.sv
// Shared SRAM arbiter types: FSM state encoding and default bus widths.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// Combinational winner selector for the SRAM arbiter.
// Build with SRAM_ARB_PRIORITY_EN for fixed priority (requester 0 highest).
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

`ifdef SRAM_ARB_PRIORITY_EN
  logic w_unused;
  assign w_unused = ^i_start;

  // Scan downwards so the lowest active index is the last one written.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_gnt    = '0;
        o_gnt[k] = 1'b1;
        o_idx    = IDX_W'(k);
        o_any    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_req[(int'(i_start) + k) % NUM_REQ]) begin
        o_gnt[(int'(i_start) + k) % NUM_REQ] = 1'b1;
        o_idx = IDX_W'((int'(i_start) + k) % NUM_REQ);
        o_any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between NUM_REQ requesters, one op at a time.
// Optional SRAM_ARB_PRIORITY_EN swaps round-robin for fixed priority.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int WRITE_CYCLES = 2,
  parameter int READ_CYCLES  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      mem_write,
  output logic                      mem_read,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 8;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_win;
  logic                r_we;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;
  logic                r_wr;
  logic                r_rd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_we;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_start (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_we = |(req_we & w_gnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any && mem_ready) begin
            r_win   <= w_idx;
            r_we    <= w_we;
            r_addr  <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[int'(w_idx)*DATA_W +: DATA_W];
            r_busy  <= 1'b1;
            r_cnt   <= w_we ? CNT_W'(WRITE_CYCLES)
                            : CNT_W'(READ_CYCLES);
            r_ptr   <= (int'(w_idx) == NUM_REQ - 1) ? '0
                                                     : w_idx + 1'b1;
            r_state <= ISSUE;
          end
        end
        // First ISSUE cycle raises the strobe; counting starts after.
        ISSUE: begin
          if (!r_wr && !r_rd) begin
            r_wr <= r_we;
            r_rd <= !r_we;
          end else if (r_cnt == CNT_W'(1)) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_state <= RELEASE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RELEASE: begin
          if (mem_ready) begin
            if (!r_we) r_rdata <= mem_rdata;
            r_ack        <= '0;
            r_ack[r_win] <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign mem_write = r_wr;
  assign mem_read  = r_rd;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sram_arbiter;

  localparam int NR = 2;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [NR-1:0]   req;
  logic [NR-1:0]   req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            mem_write;
  logic            mem_read;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;

  int errors = 0;
  int checks = 0;

  // Behavioural SRAM: one known word, everything else a filler pattern.
  assign mem_rdata = (mem_addr == 18'h3FFFF) ? 16'h1234 : 16'h0BAD;

  sram_arbiter #(
    .NUM_REQ      (NR),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .WRITE_CYCLES (2),
    .READ_CYCLES  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    checks++;
    if (ack !== 2'b00) begin
      errors++;
      $display("FAIL reset_ack got=%b exp=00", ack);
    end
    checks++;
    if (rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h exp=0000", rdata);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b%b exp=00", mem_write, mem_read);
    end
    checks++;
    if (mem_addr !== 18'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single_write;
    int wcnt = 0, rcnt = 0, acks = 0, ack_at = -1;
    logic [NR-1:0] ack_v = '0;
    logic busy_at_ack = 1'b0;
    logic bus_ok = 1'b1;
    req_we = 2'b01;
    req_addr[0 +: AW] = 18'h00010;
    req_wdata[0 +: DW] = 16'hBEEF;
    req = 2'b01;
    for (int n = 1; n <= 12; n++) begin
      tick;
      if (mem_write) begin
        wcnt++;
        if (mem_addr !== 18'h00010 || mem_wdata !== 16'hBEEF) bus_ok = 1'b0;
      end
      if (mem_read) rcnt++;
      if (ack !== 2'b00) begin
        acks++;
        if (ack_at < 0) begin
          ack_at = n;
          ack_v = ack;
          busy_at_ack = busy;
        end
        req = 2'b00;
      end
    end
    checks++;
    if (wcnt != 2 || rcnt != 0) begin
      errors++;
      $display("FAIL wr_strobe got=%0d/%0d exp=2/0", wcnt, rcnt);
    end
    checks++;
    if (!bus_ok) begin
      errors++;
      $display("FAIL wr_bus got=unstable exp=00010/BEEF");
    end
    checks++;
    if (ack_at != 5 || ack_v !== 2'b01) begin
      errors++;
      $display("FAIL wr_ack got=%0d/%b exp=5/01", ack_at, ack_v);
    end
    checks++;
    if (acks != 1 || busy_at_ack !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse got=%0d/%b/%b exp=1/1/0", acks, busy_at_ack, busy);
    end
  endtask

  task automatic test_single_read;
    int wcnt = 0, rcnt = 0, ack_at = -1;
    logic [NR-1:0] ack_v = '0;
    logic [DW-1:0] rd_v = '0;
    req_we = 2'b00;
    req_addr[AW +: AW] = 18'h3FFFF;
    req = 2'b10;
    for (int n = 1; n <= 12; n++) begin
      tick;
      if (mem_write) wcnt++;
      if (mem_read) rcnt++;
      if (ack !== 2'b00) begin
        if (ack_at < 0) begin
          ack_at = n;
          ack_v = ack;
          rd_v = rdata;
        end
        req = 2'b00;
      end
    end
    checks++;
    if (rcnt != 3 || wcnt != 0) begin
      errors++;
      $display("FAIL rd_strobe got=%0d/%0d exp=3/0", rcnt, wcnt);
    end
    checks++;
    if (ack_at != 6 || ack_v !== 2'b10) begin
      errors++;
      $display("FAIL rd_ack got=%0d/%b exp=6/10", ack_at, ack_v);
    end
    checks++;
    if (rd_v !== 16'h1234) begin
      errors++;
      $display("FAIL rd_data got=%h exp=1234", rd_v);
    end
  endtask

  task automatic test_contention;
    int wins[4];
    int exp_w[4];
    int nacks = 0;
    logic pair_ok = 1'b1;
    logic excl_ok = 1'b1;
`ifdef SRAM_ARB_PRIORITY_EN
    exp_w = '{0, 0, 0, 0};
`else
    exp_w = '{0, 1, 0, 1};
`endif
    wins = '{-1, -1, -1, -1};
    reset = 1'b1;
    req_we = 2'b11;
    req_addr[0 +: AW] = 18'h00100;
    req_addr[AW +: AW] = 18'h00200;
    req_wdata[0 +: DW] = 16'h1111;
    req_wdata[DW +: DW] = 16'h2222;
    req = 2'b11;
    tick;
    reset = 1'b0;
    for (int n = 0; n < 80 && nacks < 4; n++) begin
      tick;
      if (mem_write && mem_read) excl_ok = 1'b0;
      if (mem_write &&
          !((mem_addr == 18'h00100 && mem_wdata == 16'h1111) ||
            (mem_addr == 18'h00200 && mem_wdata == 16'h2222)))
        pair_ok = 1'b0;
      if (ack !== 2'b00) begin
        wins[nacks] = (ack == 2'b10) ? 1 : (ack == 2'b01) ? 0 : 9;
        nacks++;
      end
    end
    req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wins[k] != exp_w[k]) begin
        errors++;
        $display("FAIL cont_win%0d got=%0d exp=%0d", k, wins[k], exp_w[k]);
      end
    end
    checks++;
    if (!pair_ok || !excl_ok) begin
      errors++;
      $display("FAIL cont_bus got=%b/%b exp=1/1", pair_ok, excl_ok);
    end
    idle(6);
  endtask

  task automatic test_ready_stall;
    int ack_at = -1;
    logic hold_ok = 1'b1;
    logic in_rel;
    req_we = 2'b01;
    req_addr[0 +: AW] = 18'h0002A;
    req_wdata[0 +: DW] = 16'h5555;
    req = 2'b01;
    idle(4);
    in_rel = !mem_write && busy && mem_addr == 18'h0002A;
    checks++;
    if (!in_rel) begin
      errors++;
      $display("FAIL stall_entry got=%b/%b exp=0/1", mem_write, busy);
    end
    mem_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick;
      if (mem_write || mem_read || ack !== 2'b00 ||
          mem_addr !== 18'h0002A || mem_wdata !== 16'h5555)
        hold_ok = 1'b0;
    end
    mem_ready = 1'b1;
    for (int n = 9; n <= 16; n++) begin
      tick;
      if (ack !== 2'b00 && ack_at < 0) begin
        ack_at = n;
        req = 2'b00;
      end
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL stall_hold got=unstable exp=idle strobes");
    end
    checks++;
    if (ack_at != 9) begin
      errors++;
      $display("FAIL stall_ack got=%0d exp=9", ack_at);
    end
  endtask

  task automatic test_reset_midop;
    int ack_at = -1;
    logic stray = 1'b0;
    logic addr_ok = 1'b1;
    logic [NR-1:0] ack_v = '0;
    req_we = 2'b01;
    req_addr[0 +: AW] = 18'h00077;
    req = 2'b01;
    idle(2);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got=%b exp=1", mem_write);
    end
    reset = 1'b1;
    req = 2'b00;
    tick;
    checks++;
    if (mem_write !== 1'b0 || busy !== 1'b0 || ack !== 2'b00) begin
      errors++;
      $display("FAIL rst_abort got=%b/%b/%b exp=0/0/00", mem_write, busy, ack);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (ack !== 2'b00) stray = 1'b1;
    end
    req_we = 2'b11;
    req_addr[0 +: AW] = 18'h00040;
    req_addr[AW +: AW] = 18'h00080;
    req = 2'b11;
    for (int n = 1; n <= 10 && ack_at < 0; n++) begin
      tick;
      if (mem_write && mem_addr !== 18'h00040) addr_ok = 1'b0;
      if (ack !== 2'b00) begin
        ack_at = n;
        ack_v = ack;
        req = 2'b00;
      end
    end
    req = 2'b00;
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL rst_stray got=ack exp=none");
    end
    checks++;
    if (ack_at != 5 || ack_v !== 2'b01 || !addr_ok) begin
      errors++;
      $display("FAIL rst_fresh got=%0d/%b/%b exp=5/01/1", ack_at, ack_v, addr_ok);
    end
    idle(4);
  endtask

  task automatic test_req_withdrawn;
    int acks = 0, ack_at = -1, late_wr = 0;
    req_we = 2'b01;
    req_addr[0 +: AW] = 18'h00123;
    req_wdata[0 +: DW] = 16'hCAFE;
    req = 2'b01;
    idle(2);
    req = 2'b00;
    for (int n = 3; n <= 16; n++) begin
      tick;
      if (ack !== 2'b00) begin
        acks++;
        if (ack_at < 0) ack_at = n;
      end
      if (ack_at > 0 && n > ack_at && (mem_write || mem_read || busy))
        late_wr++;
    end
    checks++;
    if (acks != 1 || ack_at != 5) begin
      errors++;
      $display("FAIL wd_ack got=%0d@%0d exp=1@5", acks, ack_at);
    end
    checks++;
    if (late_wr != 0) begin
      errors++;
      $display("FAIL wd_regrant got=%0d exp=0", late_wr);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ready = 1'b1;
    test_reset;
    test_single_write;
    test_single_read;
    test_contention;
    test_ready_stall;
    test_reset_midop;
    test_req_withdrawn;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
